dsp_ctrl: RTL and testbench

Controller between the I2S receive path, the DSP effect core and the I2S transmit path. It debounces the freqSetting/scaleFactor switches and applies a new setting only after a click-free gain ramp-down to silence. It holds the DSP in reset at start-up and after any DSP error, then ramps the gain back up. It also scales each outgoing DSP sample by the current ramp gain before the sample goes to the I2S transmitter.

---
 rtl/dsp_ctrl_if.sv | 25 ++
 rtl/dsp_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dsp_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dsp_ctrl_if.sv
// Sample stream between the DSP core, this controller and the I2S transmitter.
interface dsp_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] pkt_i;
   logic             pktValid_i;
   logic [WIDTH-1:0] pkt_o;
   logic             pktValid_o;

   // Controller side: consumes DSP samples, produces scaled samples.
   modport slave (
      input  pkt_i,
      input  pktValid_i,
      output pkt_o,
      output pktValid_o
   );

   // Environment side: feeds DSP samples, observes scaled samples.
   modport master (
      output pkt_i,
      output pktValid_i,
      input  pkt_o,
      input  pktValid_o
   );
endinterface

// File: rtl/dsp_ctrl.sv
// DSP controller: switch debounce, click-free setting changes via gain ramps,
// DSP reset/error recovery, and per-sample gain scaling toward the I2S transmitter.
module dsp_ctrl #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned STABLE_PKTS = 8,
   parameter int unsigned RST_CYCLES  = 64
) (
   input  logic        sclk_i,
   input  logic        rst_i,
   input  logic [3:0]  freqSetting_i,
   input  logic [3:0]  scaleFactor_i,
   input  logic        dspError_i,
   dsp_ctrl_if.slave   pkt_if,
   output logic [3:0]  freqSetting_o,
   output logic [3:0]  scaleFactor_o,
   output logic        dspRst_o,
   output logic [2:0]  state_o,
   output logic [7:0]  errCount_o
);

   localparam int unsigned GAIN_W = 5;
   localparam int unsigned PROD_W = WIDTH + GAIN_W;
   localparam logic [GAIN_W-1:0] GAIN_MAX = 5'd16;
   localparam logic [7:0]  STAB_MAX  = 8'(STABLE_PKTS);
   localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_RESET_HOLD = 3'd0,
      ST_RUN        = 3'd1,
      ST_RAMP_DOWN  = 3'd2,
      ST_APPLY      = 3'd3,
      ST_RAMP_UP    = 3'd4,
      ST_RECOVER    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic [7:0]          cand_q, cand_d;
   logic [7:0]          stab_q, stab_d;
   logic [15:0]         hold_q, hold_d;
   logic [3:0]          freq_q, freq_d;
   logic [3:0]          scale_q, scale_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic                dsp_rst_q, dsp_rst_d;
   logic [WIDTH-1:0]    pkt_q, pkt_d;
   logic                pkt_valid_q, pkt_valid_d;

   logic [7:0]          raw_c;
   logic                pending_c;
   logic signed [PROD_W-1:0] prod_c;

   // State register and all datapath registers, synchronous reset.
   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         state_q     <= ST_RESET_HOLD;
         gain_q      <= '0;
         cand_q      <= '0;
         stab_q      <= '0;
         hold_q      <= '0;
         freq_q      <= '0;
         scale_q     <= '0;
         err_cnt_q   <= '0;
         dsp_rst_q   <= 1'b1;
         pkt_q       <= '0;
         pkt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gain_q      <= gain_d;
         cand_q      <= cand_d;
         stab_q      <= stab_d;
         hold_q      <= hold_d;
         freq_q      <= freq_d;
         scale_q     <= scale_d;
         err_cnt_q   <= err_cnt_d;
         dsp_rst_q   <= dsp_rst_d;
         pkt_q       <= pkt_d;
         pkt_valid_q <= pkt_valid_d;
      end
   end

   // Next-state logic: debounce, sample scaling and the control FSM.
   always_comb begin
      state_d     = state_q;
      gain_d      = gain_q;
      cand_d      = cand_q;
      stab_d      = stab_q;
      hold_d      = hold_q;
      freq_d      = freq_q;
      scale_d     = scale_q;
      err_cnt_d   = err_cnt_q;
      dsp_rst_d   = dsp_rst_q;
      pkt_d       = pkt_q;
      pkt_valid_d = pkt_if.pktValid_i;

      raw_c     = {freqSetting_i, scaleFactor_i};
      pending_c = (stab_q == STAB_MAX) && (cand_q != {freq_q, scale_q});

      // Scale with the gain held before this cycle's ramp step.
      prod_c = PROD_W'($signed(pkt_if.pkt_i)) * PROD_W'($signed({1'b0, gain_q}));

      if (pkt_if.pktValid_i) begin
         pkt_d = WIDTH'(prod_c >>> 4);
         if (raw_c == cand_q) begin
            if (stab_q != STAB_MAX) begin
               stab_d = stab_q + 8'd1;
            end
         end else begin
            cand_d = raw_c;
            stab_d = '0;
         end
      end

      case (state_q)
         ST_RESET_HOLD, ST_RECOVER: begin
            if (hold_q == HOLD_LAST) begin
               state_d   = ST_RAMP_UP;
               hold_d    = '0;
               dsp_rst_d = 1'b0;
            end else begin
               hold_d = hold_q + 16'd1;
            end
         end
         ST_RUN: begin
            gain_d = GAIN_MAX;
            if (dspError_i) begin
               state_d = ST_RECOVER;
            end else if (pending_c) begin
               state_d = ST_RAMP_DOWN;
            end
         end
         ST_RAMP_DOWN: begin
            if (dspError_i) begin
               state_d = ST_RECOVER;
            end else if (pkt_if.pktValid_i) begin
               gain_d = gain_q - 5'd1;
               if (gain_q == 5'd1) begin
                  state_d = ST_APPLY;
               end
            end
         end
         ST_APPLY: begin
            freq_d  = cand_q[7:4];
            scale_d = cand_q[3:0];
            state_d = ST_RAMP_UP;
         end
         ST_RAMP_UP: begin
            if (dspError_i) begin
               state_d = ST_RECOVER;
            end else if (pkt_if.pktValid_i) begin
               gain_d = gain_q + 5'd1;
               if (gain_q == 5'd15) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            state_d = ST_RESET_HOLD;
         end
      endcase

      // Entering recovery silences the output and puts the DSP back in reset.
      if ((state_q != ST_RECOVER) && (state_d == ST_RECOVER)) begin
         gain_d    = '0;
         hold_d    = '0;
         dsp_rst_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   // Registered outputs.
   assign freqSetting_o     = freq_q;
   assign scaleFactor_o     = scale_q;
   assign dspRst_o          = dsp_rst_q;
   assign state_o           = state_q;
   assign errCount_o        = err_cnt_q;
   assign pkt_if.pkt_o      = pkt_q;
   assign pkt_if.pktValid_o = pkt_valid_q;

endmodule

// File: tb/tb_dsp_ctrl.sv
// Directed bench for dsp_ctrl: start-up hold, ramps, debounce, error recovery, reset.
module tb_dsp_ctrl;

   logic       sclk = 1'b0;
   logic       rst;
   logic       err;
   logic [3:0] fs_i, sf_i, fs_o, sf_o;
   logic       dsp_rst;
   logic [2:0] st;
   logic [7:0] ec;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] din;
      logic [15:0] dout;
      logic [2:0]  st;
   } vec_t;

   vec_t up_v[20];
   vec_t dn_v[16];

   always #5 sclk = ~sclk;

   dsp_ctrl_if #(.WIDTH(16)) pkt_if ();

   dsp_ctrl #(.WIDTH(16), .STABLE_PKTS(8), .RST_CYCLES(64)) dut (
      .sclk_i        (sclk),
      .rst_i         (rst),
      .freqSetting_i (fs_i),
      .scaleFactor_i (sf_i),
      .dspError_i    (err),
      .pkt_if        (pkt_if),
      .freqSetting_o (fs_o),
      .scaleFactor_o (sf_o),
      .dspRst_o      (dsp_rst),
      .state_o       (st),
      .errCount_o    (ec)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic send(input logic [15:0] d);
      pkt_if.pkt_i      = d;
      pkt_if.pktValid_i = 1'b1;
      tick();
      pkt_if.pktValid_i = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_freq"},   32'(fs_o), 32'd0);
      check({tag, "_scale"},  32'(sf_o), 32'd0);
      check({tag, "_dsprst"}, 32'(dsp_rst), 32'd1);
      check({tag, "_pkt"},    32'(pkt_if.pkt_o), 32'd0);
      check({tag, "_pktv"},   32'(pkt_if.pktValid_o), 32'd0);
      check({tag, "_state"},  32'(st), 32'd0);
      check({tag, "_errcnt"}, 32'(ec), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Ramp-up of 0x4000: gain 0..15, then pass-through in RUN.
      for (int k = 0; k < 20; k++) begin
         up_v[k].din  = 16'h4000;
         up_v[k].dout = (k < 16) ? 16'(k * 16'h0400) : 16'h4000;
         up_v[k].st   = (k < 15) ? 3'd4 : 3'd1;
      end
      // Ramp-down of 0x0100: gain 16..1, landing in APPLY.
      for (int k = 0; k < 16; k++) begin
         dn_v[k].din  = 16'h0100;
         dn_v[k].dout = 16'((16 - k) * 16);
         dn_v[k].st   = (k < 15) ? 3'd2 : 3'd3;
      end

      rst = 1'b1;
      err = 1'b0;
      fs_i = 4'd0;
      sf_i = 4'd0;
      pkt_if.pkt_i = '0;
      pkt_if.pktValid_i = 1'b0;
      repeat (3) tick();
      check_reset_vals("por");

      // Start-up hold: 64 cycles of DSP reset, then RAMP_UP.
      rst = 1'b0;
      repeat (63) tick();
      check("hold63_state", 32'(st), 32'd0);
      check("hold63_dsprst", 32'(dsp_rst), 32'd1);
      tick();
      check("hold64_state", 32'(st), 32'd4);
      check("hold64_dsprst", 32'(dsp_rst), 32'd0);
      check("hold64_errcnt", 32'(ec), 32'd0);

      // First ramp-up, table driven.
      for (int k = 0; k < 20; k++) begin
         send(up_v[k].din);
         check($sformatf("upA_pkt%0d", k), 32'(pkt_if.pkt_o), 32'(up_v[k].dout));
         check($sformatf("upA_st%0d", k), 32'(st), 32'(up_v[k].st));
         if (k == 0) check("upA_pktv", 32'(pkt_if.pktValid_o), 32'd1);
         tick();
      end
      check("hold_pkt", 32'(pkt_if.pkt_o), 32'h4000);
      check("hold_pktv", 32'(pkt_if.pktValid_o), 32'd0);

      // Switches toggling every 4 packets never become pending.
      for (int k = 0; k < 16; k++) begin
         {fs_i, sf_i} = ((k / 4) % 2 == 1) ? 8'h74 : 8'h21;
         send(16'h1234);
         check($sformatf("tog_st%0d", k), 32'(st), 32'd1);
         tick();
      end
      check("tog_pkt", 32'(pkt_if.pkt_o), 32'h1234);
      check("tog_freq", 32'(fs_o), 32'd0);
      check("tog_scale", 32'(sf_o), 32'd0);

      // New setting 5/3: one packet loads the candidate, eight more saturate it.
      fs_i = 4'd5;
      sf_i = 4'd3;
      for (int k = 0; k < 9; k++) begin
         send(16'hFFFF);
         check($sformatf("deb_pkt%0d", k), 32'(pkt_if.pkt_o), 32'hFFFF);
         check($sformatf("deb_st%0d", k), 32'(st), 32'd1);
         tick();
      end
      check("rd_enter_state", 32'(st), 32'd2);

      // Ramp down gains 16..10 with -1 input: floor rounding keeps -1.
      for (int k = 0; k < 7; k++) begin
         send(16'hFFFF);
         check($sformatf("rdA_pkt%0d", k), 32'(pkt_if.pkt_o), 32'hFFFF);
         check($sformatf("rdA_st%0d", k), 32'(st), 32'd2);
         tick();
      end

      // Error at gain 9 during ramp-down.
      err = 1'b1;
      tick();
      err = 1'b0;
      check("rec_state", 32'(st), 32'd5);
      check("rec_dsprst", 32'(dsp_rst), 32'd1);
      check("rec_errcnt", 32'(ec), 32'd1);
      check("rec_freq", 32'(fs_o), 32'd0);
      send(16'h1234);
      check("rec_pkt_gain0", 32'(pkt_if.pkt_o), 32'd0);
      repeat (62) tick();
      check("rec63_state", 32'(st), 32'd5);
      check("rec63_dsprst", 32'(dsp_rst), 32'd1);
      tick();
      check("rec64_state", 32'(st), 32'd4);
      check("rec64_dsprst", 32'(dsp_rst), 32'd0);
      check("rec64_scale", 32'(sf_o), 32'd0);

      // Ramp back up; the change is still pending so RUN lasts one cycle.
      for (int k = 0; k < 16; k++) begin
         send(up_v[k].din);
         check($sformatf("upB_pkt%0d", k), 32'(pkt_if.pkt_o), 32'(up_v[k].dout));
         check($sformatf("upB_st%0d", k), 32'(st), 32'(up_v[k].st));
         tick();
      end
      check("rdB_enter_state", 32'(st), 32'd2);

      for (int k = 0; k < 16; k++) begin
         send(dn_v[k].din);
         check($sformatf("rdB_pkt%0d", k), 32'(pkt_if.pkt_o), 32'(dn_v[k].dout));
         check($sformatf("rdB_st%0d", k), 32'(st), 32'(dn_v[k].st));
         if (k < 15) tick();
      end
      check("apply_freq_before", 32'(fs_o), 32'd0);

      // APPLY cycle: packet scaled by 0, error ignored, setting applied.
      err = 1'b1;
      send(16'h4000);
      err = 1'b0;
      check("apply_pkt", 32'(pkt_if.pkt_o), 32'd0);
      check("apply_state", 32'(st), 32'd4);
      check("apply_freq", 32'(fs_o), 32'd5);
      check("apply_scale", 32'(sf_o), 32'd3);
      check("apply_errcnt", 32'(ec), 32'd1);
      tick();

      for (int k = 0; k < 3; k++) begin
         send(up_v[k].din);
         check($sformatf("upC_pkt%0d", k), 32'(pkt_if.pkt_o), 32'(up_v[k].dout));
         check($sformatf("upC_st%0d", k), 32'(st), 32'd4);
         tick();
      end

      // Reset mid ramp-up returns everything to reset values.
      rst = 1'b1;
      tick();
      check_reset_vals("midrst");
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
